datapath: RTL and testbench
===========================

# datapath

Single-cycle MIPS datapath: the consumer end of the control bus produced by the team's `controller`. It holds the program counter and the 32×32 register file, sign-extends immediates, and runs the ALU. It selects the next PC, the write register and the write-back data under the controller's signals. It returns the decode fields (`op`, `funct`) and the `zero` flag, so the `controller` closes the loop. It sits in the CPU top between instruction memory, data memory and the `controller`.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded by reset.

Ports:
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `reset`, input, 1, reset is synchronous and active-high.
- `memtoreg`, input, 1, write-back source: 1 = `readdata`, 0 = ALU result.
- `pcsrc`, input, 1, take branch target (already `branch & zero`).
- `alusrc`, input, 1, ALU B operand: 1 = sign-extended immediate, 0 = rt register.
- `regdst`, input, 1, destination: 1 = `instr[15:11]` (rd), 0 = `instr[20:16]` (rt).
- `regwrite`, input, 1, register-file write enable.
- `jump`, input, 1, take jump target.
- `alucontrol`, input, 3, ALU operation select.
- `instr`, input, 32, instruction fetched at `pc`.
- `readdata`, input, 32, data-memory read data.
- `op`, output, 6, `instr[31:26]`.
- `funct`, output, 6, `instr[5:0]`.
- `zero`, output, 1, high when the ALU result is 32'h0.
- `pc`, output, 32, current program counter.
- `aluout`, output, 32, ALU result, which also serves as the data-memory address.
- `writedata`, output, 32, rt register read data, driven to data memory.
- `memwrite` is not an input. It goes from the `controller` straight to data memory.

## Operation

- Sign extension: `signimm = {{16{instr[15]}}, instr[15:0]}`.
- Register reads are combinational. `rd1 = R[instr[25:21]]`, `rd2 = R[instr[20:16]]`. Register 0 always reads 32'h0.
- ALU operands: `srca = rd1`; `srcb = alusrc ? signimm : rd2`.
- ALU operations:
  - 000 AND.
  - 001 OR.
  - 010 ADD, modulo 2^32, no overflow trap.
  - 110 SUB, modulo 2^32.
  - 111 SLT, signed compare: 32'h1 if `srca < srcb`, else 32'h0.
  - 011, 100, 101 produce 32'h0, so `zero = 1`.
- Write-back: `result = memtoreg ? readdata : aluout`.
- Write register: `wa = regdst ? instr[15:11] : instr[20:16]`.
- Write condition: on a rising edge with `regwrite = 1` and `reset = 0`, `R[wa] <= result`. A write to register 0 is discarded.
- Next PC:
  - `pcplus4 = pc + 4`, modulo 2^32.
  - `pcbranch = pcplus4 + (signimm << 2)`, modulo 2^32.
  - `pcjump = {pcplus4[31:28], instr[25:0], 2'b00}`.
  - Priority: `jump` over `pcsrc` over sequential. `pcnext = jump ? pcjump : (pcsrc ? pcbranch : pcplus4)`.
- Reset: on a rising edge with `reset = 1`, `pc <= RESET_PC` and all 32 registers are cleared to 0. Reset dominates `regwrite`, `jump` and `pcsrc`.

## Timing

- PC and the register file are the only state elements. Everything else is combinational from `instr`, `readdata`, state and the control inputs.
- Every instruction has one-cycle latency: `pc` updates on the edge that ends the cycle.
- Read-during-write: a read in the same cycle as a write to the same register returns the old value. The new value is visible the cycle after the edge.
- Reset values:
  - `pc = RESET_PC`; all registers 0.
  - `writedata = 0`.
  - `aluout` follows from zero registers and the current `instr`/`alucontrol`.
  - `op` and `funct` mirror `instr`.
- Reset asserted mid-program: on the next edge `pc` returns to `RESET_PC` and the register file clears. A pending write in that cycle is lost.
- PC wrap: `pc = 32'hFFFF_FFFC` with sequential flow gives `pc = 32'h0000_0000` next.
- Simultaneous `jump` and `pcsrc`: jump target taken.

## Test plan

- **Reset.** Hold `reset` for 2 cycles with `regwrite = 1`, `jump = 1` → `pc = 0`, and reading any register gives 0.
- **Immediate add then R-type.**
  - ADDI-style cycle: `alusrc = 1`, `alucontrol = 010`, `regwrite = 1`, `regdst = 0`, `instr = 32'h2008_0005` → `$8 = 5`, `pc` advances by 4.
  - Next cycle: SUB `$9 = $8 - $8` → `aluout = 0`, `zero = 1`, `$9 = 0`.
- **Branch.** Drive `pcsrc = 1` with `instr[15:0] = 16'hFFFF` at `pc = 32'h10` → next `pc = 32'h10`. With `16'h0003` → next `pc = 32'h20`.
- **Jump priority.** At `pc = 32'h4000_0000`, drive `jump = 1`, `pcsrc = 1`, `instr[25:0] = 26'h000_0010` → next `pc = 32'h4000_0040`.
- **Load and register 0.**
  - `memtoreg = 1`, `readdata = 32'hDEAD_BEEF`, `wa = 10` → `$10 = 32'hDEAD_BEEF`.
  - The same write with `wa = 0` → `$0` still reads 0.
- **SLT signedness and PC wrap.**
  - `$1 = 32'hFFFF_FFFF`, `$2 = 1`, `alucontrol = 111` → `aluout = 1`. With the operands swapped → 0.
  - `RESET_PC = 32'hFFFF_FFFC` with one sequential step → `pc = 0`.

Source files
------------

// File: rtl/datapath.sv
// Single-cycle MIPS datapath: program counter, 32x32 register file,
// immediate sign extension, ALU, next-PC selection and write-back mux.
module datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memtoreg,
    input  logic        pcsrc,
    input  logic        alusrc,
    input  logic        regdst,
    input  logic        regwrite,
    input  logic        jump,
    input  logic [2:0]  alucontrol,
    input  logic [31:0] instr,
    input  logic [31:0] readdata,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        zero,
    output logic [31:0] pc,
    output logic [31:0] aluout,
    output logic [31:0] writedata
);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    logic [4:0]  rs, rt, rd, wa;
    logic [31:0] signimm;
    logic [31:0] rd1, rd2;
    logic [31:0] srca, srcb;
    logic [31:0] alu_res;
    logic [31:0] result;
    logic [31:0] pcplus4, pcbranch, pcjump;

    // Instruction field decode and immediate sign extension.
    always_comb begin
        rs      = instr[25:21];
        rt      = instr[20:16];
        rd      = instr[15:11];
        signimm = {{16{instr[15]}}, instr[15:0]};
    end

    // Combinational register reads; $0 is hardwired to zero on the read side.
    always_comb begin
        rd1 = (rs == 5'd0) ? 32'h0 : rf_q[rs];
        rd2 = (rt == 5'd0) ? 32'h0 : rf_q[rt];
    end

    // ALU; unused encodings yield zero so the zero flag is raised.
    always_comb begin
        srca = rd1;
        srcb = alusrc ? signimm : rd2;
        case (alucontrol)
            ALU_AND: alu_res = srca & srcb;
            ALU_OR:  alu_res = srca | srcb;
            ALU_ADD: alu_res = srca + srcb;
            ALU_SUB: alu_res = srca - srcb;
            ALU_SLT: alu_res = ($signed(srca) < $signed(srcb)) ? 32'h1 : 32'h0;
            default: alu_res = 32'h0;
        endcase
    end

    // Write-back data, destination register and next register-file contents.
    always_comb begin
        result = memtoreg ? readdata : alu_res;
        wa     = regdst ? rd : rt;
        rf_d   = rf_q;
        if (regwrite && (wa != 5'd0)) begin
            rf_d[wa] = result;
        end
    end

    // Next PC: jump beats branch beats sequential.
    always_comb begin
        pcplus4  = pc_q + 32'd4;
        pcbranch = pcplus4 + {signimm[29:0], 2'b00};
        pcjump   = {pcplus4[31:28], instr[25:0], 2'b00};
        if (jump) begin
            pc_d = pcjump;
        end else if (pcsrc) begin
            pc_d = pcbranch;
        end else begin
            pc_d = pcplus4;
        end
    end

    // PC and register file state; reset wins over any pending write or jump.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'h0;
            end
        end else begin
            pc_q <= pc_d;
            rf_q <= rf_d;
        end
    end

    // Output drive.
    always_comb begin
        op        = instr[31:26];
        funct     = instr[5:0];
        pc        = pc_q;
        aluout    = alu_res;
        zero      = (alu_res == 32'h0);
        writedata = rd2;
    end

endmodule

// File: tb/tb_datapath.sv
// Directed test of the single-cycle MIPS datapath.
module tb_datapath;

    logic        clk;
    logic        reset, reset_x;
    logic        memtoreg, pcsrc, alusrc, regdst, regwrite, jump;
    logic [2:0]  alucontrol;
    logic [31:0] instr, readdata;

    logic [5:0]  op, funct, op_w, funct_w, op_h, funct_h;
    logic        zero, zero_w, zero_h;
    logic [31:0] pc, aluout, writedata;
    logic [31:0] pc_w, aluout_w, writedata_w;
    logic [31:0] pc_h, aluout_h, writedata_h;

    int n_checks = 0;
    int n_fail   = 0;

    datapath dut (
        .clk(clk), .reset(reset), .memtoreg(memtoreg), .pcsrc(pcsrc),
        .alusrc(alusrc), .regdst(regdst), .regwrite(regwrite), .jump(jump),
        .alucontrol(alucontrol), .instr(instr), .readdata(readdata),
        .op(op), .funct(funct), .zero(zero), .pc(pc), .aluout(aluout),
        .writedata(writedata)
    );

    datapath #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(reset_x), .memtoreg(memtoreg), .pcsrc(pcsrc),
        .alusrc(alusrc), .regdst(regdst), .regwrite(regwrite), .jump(jump),
        .alucontrol(alucontrol), .instr(instr), .readdata(readdata),
        .op(op_w), .funct(funct_w), .zero(zero_w), .pc(pc_w), .aluout(aluout_w),
        .writedata(writedata_w)
    );

    datapath #(.RESET_PC(32'h4000_0000)) u_hi (
        .clk(clk), .reset(reset_x), .memtoreg(memtoreg), .pcsrc(pcsrc),
        .alusrc(alusrc), .regdst(regdst), .regwrite(regwrite), .jump(jump),
        .alucontrol(alucontrol), .instr(instr), .readdata(readdata),
        .op(op_h), .funct(funct_h), .zero(zero_h), .pc(pc_h), .aluout(aluout_h),
        .writedata(writedata_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ctrl();
        memtoreg   = 1'b0;
        pcsrc      = 1'b0;
        alusrc     = 1'b0;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        jump       = 1'b0;
        alucontrol = 3'b010;
        readdata   = 32'h0;
    endtask

    task automatic test_reset();
        idle_ctrl();
        reset    = 1'b1;
        reset_x  = 1'b1;
        regwrite = 1'b1;
        jump     = 1'b1;
        pcsrc    = 1'b1;
        instr    = 32'h2008_0005;
        alusrc   = 1'b1;
        step();
        step();
        regwrite = 1'b0;
        jump     = 1'b0;
        pcsrc    = 1'b0;
        alusrc   = 1'b0;
        #1;
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
        for (int r = 0; r < 32; r++) begin
            instr = {6'd0, 5'(r), 5'(r), 16'h0};
            #1;
            n_checks++; if (writedata !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected %h", r, writedata, 32'h0); end
        end
        reset   = 1'b0;
        reset_x = 1'b0;
    endtask

    task automatic test_addi_sub();
        idle_ctrl();
        alusrc   = 1'b1;
        regwrite = 1'b1;
        instr    = 32'h2008_0005;
        #1;
        n_checks++; if (aluout !== 32'h5) begin n_fail++; $display("FAIL addi_alu: got %h expected %h", aluout, 32'h5); end
        n_checks++; if (writedata !== 32'h0) begin n_fail++; $display("FAIL addi_rdw_old: got %h expected %h", writedata, 32'h0); end
        n_checks++; if (op !== 6'h08) begin n_fail++; $display("FAIL addi_op: got %h expected %h", op, 6'h08); end
        step();
        n_checks++; if (pc !== 32'h4) begin n_fail++; $display("FAIL addi_pc: got %h expected %h", pc, 32'h4); end
        alusrc     = 1'b0;
        regdst     = 1'b1;
        alucontrol = 3'b110;
        instr      = 32'h0108_4822;
        #1;
        n_checks++; if (writedata !== 32'h5) begin n_fail++; $display("FAIL addi_r8: got %h expected %h", writedata, 32'h5); end
        n_checks++; if (aluout !== 32'h0) begin n_fail++; $display("FAIL sub_alu: got %h expected %h", aluout, 32'h0); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL sub_zero: got %b expected %b", zero, 1'b1); end
        n_checks++; if (funct !== 6'h22) begin n_fail++; $display("FAIL sub_funct: got %h expected %h", funct, 6'h22); end
        step();
        n_checks++; if (pc !== 32'h8) begin n_fail++; $display("FAIL sub_pc: got %h expected %h", pc, 32'h8); end
        idle_ctrl();
        instr = 32'h0128_0000;
        #1;
        n_checks++; if (aluout !== 32'h5) begin n_fail++; $display("FAIL sub_r9: got %h expected %h", aluout, 32'h5); end
        n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL add_nz: got %b expected %b", zero, 1'b0); end
    endtask

    task automatic test_branch();
        idle_ctrl();
        instr = 32'h0;
        step();
        step();
        n_checks++; if (pc !== 32'h10) begin n_fail++; $display("FAIL seq_pc: got %h expected %h", pc, 32'h10); end
        pcsrc = 1'b1;
        instr = 32'h1000_FFFF;
        step();
        n_checks++; if (pc !== 32'h10) begin n_fail++; $display("FAIL branch_back: got %h expected %h", pc, 32'h10); end
        instr = 32'h1000_0003;
        step();
        n_checks++; if (pc !== 32'h20) begin n_fail++; $display("FAIL branch_fwd: got %h expected %h", pc, 32'h20); end
        pcsrc = 1'b0;
    endtask

    task automatic test_load_r0();
        idle_ctrl();
        memtoreg = 1'b1;
        regwrite = 1'b1;
        regdst   = 1'b1;
        readdata = 32'hDEAD_BEEF;
        instr    = 32'h0000_5000;
        step();
        instr = 32'h0000_0000;
        step();
        idle_ctrl();
        instr = 32'h000A_0000;
        #1;
        n_checks++; if (writedata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_r10: got %h expected %h", writedata, 32'hDEAD_BEEF); end
        n_checks++; if (aluout !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_alu: got %h expected %h", aluout, 32'hDEAD_BEEF); end
        instr = 32'h0000_0000;
        #1;
        n_checks++; if (writedata !== 32'h0) begin n_fail++; $display("FAIL r0_write: got %h expected %h", writedata, 32'h0); end
        n_checks++; if (pc !== 32'h28) begin n_fail++; $display("FAIL load_pc: got %h expected %h", pc, 32'h28); end
    endtask

    task automatic test_mid_reset();
        idle_ctrl();
        memtoreg = 1'b1;
        regwrite = 1'b1;
        regdst   = 1'b1;
        jump     = 1'b1;
        readdata = 32'h1234_5678;
        instr    = 32'h0000_5800;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        idle_ctrl();
        #1;
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL midreset_pc: got %h expected %h", pc, 32'h0); end
        instr = 32'h000A_0000;
        #1;
        n_checks++; if (writedata !== 32'h0) begin n_fail++; $display("FAIL midreset_r10: got %h expected %h", writedata, 32'h0); end
        instr = 32'h000B_0000;
        #1;
        n_checks++; if (writedata !== 32'h0) begin n_fail++; $display("FAIL midreset_r11: got %h expected %h", writedata, 32'h0); end
    endtask

    task automatic test_alu_ops();
        idle_ctrl();
        alusrc   = 1'b1;
        regwrite = 1'b1;
        instr    = 32'h2001_FFFF;
        #1;
        n_checks++; if (aluout !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL addi_neg: got %h expected %h", aluout, 32'hFFFF_FFFF); end
        step();
        instr = 32'h2002_0001;
        step();
        idle_ctrl();
        alucontrol = 3'b111;
        instr      = 32'h0022_182A;
        #1;
        n_checks++; if (aluout !== 32'h1) begin n_fail++; $display("FAIL slt_neg: got %h expected %h", aluout, 32'h1); end
        n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL slt_neg_zero: got %b expected %b", zero, 1'b0); end
        instr = 32'h0041_182A;
        #1;
        n_checks++; if (aluout !== 32'h0) begin n_fail++; $display("FAIL slt_pos: got %h expected %h", aluout, 32'h0); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL slt_pos_zero: got %b expected %b", zero, 1'b1); end
        instr      = 32'h0022_1824;
        alucontrol = 3'b000;
        #1;
        n_checks++; if (aluout !== 32'h1) begin n_fail++; $display("FAIL and: got %h expected %h", aluout, 32'h1); end
        alucontrol = 3'b001;
        #1;
        n_checks++; if (aluout !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL or: got %h expected %h", aluout, 32'hFFFF_FFFF); end
        alucontrol = 3'b010;
        #1;
        n_checks++; if (aluout !== 32'h0) begin n_fail++; $display("FAIL add_wrap: got %h expected %h", aluout, 32'h0); end
        alucontrol = 3'b110;
        #1;
        n_checks++; if (aluout !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sub: got %h expected %h", aluout, 32'hFFFF_FFFE); end
        for (int k = 3; k <= 5; k++) begin
            alucontrol = 3'(k);
            #1;
            n_checks++; if (aluout !== 32'h0 || zero !== 1'b1) begin n_fail++; $display("FAIL unused_op%0d: got %h/%b expected %h/%b", k, aluout, zero, 32'h0, 1'b1); end
        end
    endtask

    task automatic test_wrap_jump();
        idle_ctrl();
        instr   = 32'h0000_0020;
        reset_x = 1'b1;
        step();
        reset_x = 1'b0;
        #1;
        n_checks++; if (pc_w !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_reset_pc: got %h expected %h", pc_w, 32'hFFFF_FFFC); end
        n_checks++; if (pc_h !== 32'h4000_0000) begin n_fail++; $display("FAIL hi_reset_pc: got %h expected %h", pc_h, 32'h4000_0000); end
        n_checks++; if (aluout_w !== 32'h0 || zero_w !== 1'b1 || writedata_w !== 32'h0) begin n_fail++; $display("FAIL wrap_reset_out: got %h/%b/%h expected 0/1/0", aluout_w, zero_w, writedata_w); end
        n_checks++; if (aluout_h !== 32'h0 || zero_h !== 1'b1 || writedata_h !== 32'h0) begin n_fail++; $display("FAIL hi_reset_out: got %h/%b/%h expected 0/1/0", aluout_h, zero_h, writedata_h); end
        n_checks++; if (op_w !== 6'h0 || funct_w !== 6'h20 || op_h !== 6'h0 || funct_h !== 6'h20) begin n_fail++; $display("FAIL alt_decode: got %h %h %h %h expected 00 20 00 20", op_w, funct_w, op_h, funct_h); end
        step();
        n_checks++; if (pc_w !== 32'h0) begin n_fail++; $display("FAIL pc_wrap: got %h expected %h", pc_w, 32'h0); end
        reset_x = 1'b1;
        step();
        reset_x = 1'b0;
        jump    = 1'b1;
        pcsrc   = 1'b1;
        instr   = 32'h0800_0010;
        step();
        n_checks++; if (pc_h !== 32'h4000_0040) begin n_fail++; $display("FAIL jump_prio: got %h expected %h", pc_h, 32'h4000_0040); end
        n_checks++; if (pc_w !== 32'h0000_0040) begin n_fail++; $display("FAIL jump_wrap: got %h expected %h", pc_w, 32'h0000_0040); end
        idle_ctrl();
    endtask

    initial begin
        reset   = 1'b1;
        reset_x = 1'b1;
        instr   = 32'h0;
        idle_ctrl();
        test_reset();
        test_addi_sub();
        test_branch();
        test_load_r0();
        test_mid_reset();
        test_alu_ops();
        test_wrap_jump();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
